crg_triple_fifo: RTL and testbench

Output buffer for the correlated random generator. It captures every (a, b, c) triple the generator emits on its valid strobe and queues it in a DEPTH-entry FIFO. It presents the head triple to the consumer (MPC engine / host DMA) over a valid/ready handshake. The generator pipeline cannot stall, so this block exports its free-entry count; the issuing controller must never launch more triples than that count allows.

---
 rtl/crg_triple_fifo.sv | 91 +++++++++
 tb/tb_crg_triple_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crg_triple_fifo.sv
// rtl/crg_triple_fifo.sv - show-ahead triple FIFO for the correlated random generator
// Optional pop/drop statistics counters: define CRG_TRIPLE_FIFO_STATS_EN.
module crg_triple_fifo #(
  parameter  int DATA_W = 256,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic              dvld_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] c_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AW:0]       level_o,
  output logic [AW:0]       free_o,
  output logic              ovf_o,
  output logic [31:0]       pop_cnt_o,
  output logic [15:0]       drop_cnt_o
);

  logic [3*DATA_W-1:0] mem [DEPTH];
  logic [AW:0]         wp, rp, level;
  logic                full, pop, push, drop;
  logic [3*DATA_W-1:0] head;

  assign level = wp - rp;
  assign full  = (level == (AW+1)'(DEPTH));
  assign valid_o = (level != '0);
  assign pop   = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = dvld_i && (!full || pop);
  assign drop  = dvld_i && full && !pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp    <= '0;
      rp    <= '0;
      ovf_o <= 1'b0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (drop) ovf_o <= 1'b1;
    end
  end

  // Storage is intentionally left unreset; the gated outputs hide stale data.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wp[AW-1:0]] <= {a_i, b_i, c_i};
  end

  assign head = mem[rp[AW-1:0]];
  assign a_o  = valid_o ? head[3*DATA_W-1:2*DATA_W] : '0;
  assign b_o  = valid_o ? head[2*DATA_W-1:DATA_W]   : '0;
  assign c_o  = valid_o ? head[DATA_W-1:0]          : '0;

  assign level_o = level;
  assign free_o  = (AW+1)'(DEPTH) - level;

`ifdef CRG_TRIPLE_FIFO_STATS_EN
  logic [31:0] pop_cnt;
  logic [15:0] drop_cnt;

  // Only reset clears the statistics; flush suppresses counting for its cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pop_cnt  <= '0;
      drop_cnt <= '0;
    end else if (!flush_i) begin
      if (pop) pop_cnt <= pop_cnt + 32'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign pop_cnt_o  = pop_cnt;
  assign drop_cnt_o = drop_cnt;
`else
  assign pop_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_crg_triple_fifo.sv
// tb/tb_crg_triple_fifo.sv - scoreboard bench for crg_triple_fifo
module tb_crg_triple_fifo;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
`ifdef CRG_TRIPLE_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } trip_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] a_i = '0, b_i = '0, c_i = '0;
  logic              dvld = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [DATA_W-1:0] a_o, b_o, c_o;
  logic              valid_o, ovf_o;
  logic [AW:0]       level_o, free_o;
  logic [31:0]       pop_cnt_o;
  logic [15:0]       drop_cnt_o;

  trip_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  crg_triple_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .dvld_i(dvld), .flush_i(flush),
    .a_o(a_o), .b_o(b_o), .c_o(c_o),
    .valid_o(valid_o), .ready_i(ready),
    .level_o(level_o), .free_o(free_o), .ovf_o(ovf_o),
    .pop_cnt_o(pop_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected triple.
  always @(negedge clk) begin
    if (rst_n && !flush && valid_o && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        trip_t e;
        e = sb.pop_front();
        check("pop_a", a_o, e.a);
        check("pop_b", b_o, e.b);
        check("pop_c", c_o, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trip(input int a, input int b, input int c, input bit expect_write);
    trip_t t;
    a_i = DATA_W'(a); b_i = DATA_W'(b); c_i = DATA_W'(c);
    t.a = a_i; t.b = b_i; t.c = c_i;
    if (expect_write) sb.push_back(t);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      set_trip(base + i, base + i + 100, base + i + 200, 1'b1);
      dvld = 1'b1;
      step();
    end
    dvld = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int k = 0; k < 200 && valid_o; k++) step();
    ready = 1'b0;
    @(negedge clk);
    check("drain_valid", valid_o, 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_a", a_o, 0);
    check("rst_b", b_o, 0);
    check("rst_c", c_o, 0);
    check("rst_level", level_o, 0);
    check("rst_free", free_o, 64);
    check("rst_ovf", ovf_o, 0);
    check("rst_popcnt", pop_cnt_o, 0);
    check("rst_dropcnt", drop_cnt_o, 0);

    // Ordering: ten triples, then continuous pops
    @(posedge clk); #1;
    push_n(10, 0);
    @(negedge clk);
    check("ord_level_full", level_o, 10);
    check("ord_head_a", a_o, 0);
    check("ord_head_c", c_o, 200);
    @(posedge clk); #1;
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("ord_level", level_o, 10 - k);
      step();
    end
    ready = 1'b0;
    @(negedge clk);
    check("ord_level_end", level_o, 0);
    check("ord_valid_end", valid_o, 0);
    check("ord_a_zero", a_o, 0);

    // Full with simultaneous push and pop
    @(posedge clk); #1;
    push_n(64, 1000);
    @(negedge clk);
    check("full_level", level_o, 64);
    check("full_free", free_o, 0);
    @(posedge clk); #1;
    for (int j = 0; j < 5; j++) begin
      set_trip(2000 + j, 2100 + j, 2200 + j, 1'b1);
      dvld = 1'b1; ready = 1'b1;
      @(negedge clk);
      check("full_pp_level", level_o, 64);
      step();
    end
    dvld = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("full_pp_level_after", level_o, 64);
    check("full_pp_ovf", ovf_o, 0);
    check("full_pp_drop", drop_cnt_o, 0);

    // Overflow: three drops while full and stalled
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      set_trip(3000 + j, 3100 + j, 3200 + j, 1'b0);
      dvld = 1'b1;
      step();
    end
    dvld = 1'b0;
    @(negedge clk);
    check("ovf_flag", ovf_o, 1);
    check("ovf_dropcnt", drop_cnt_o, STATS ? 3 : 0);
    check("ovf_level", level_o, 64);
    check("ovf_head_a", a_o, sb[0].a);
    @(posedge clk); #1;
    drain();
    check("ovf_sticky", ovf_o, 1);
    check("popcnt_79", pop_cnt_o, STATS ? 79 : 0);

    // Flush beats a concurrent push and pop
    @(posedge clk); #1;
    push_n(20, 4000);
    set_trip(5000, 5100, 5200, 1'b0);
    dvld = 1'b1; ready = 1'b1; flush = 1'b1;
    step();
    dvld = 1'b0; ready = 1'b0; flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_level", level_o, 0);
    check("flush_valid", valid_o, 0);
    check("flush_ovf", ovf_o, 0);
    check("flush_a", a_o, 0);
    check("flush_dropcnt", drop_cnt_o, STATS ? 3 : 0);
    check("flush_popcnt", pop_cnt_o, STATS ? 79 : 0);

    // Asynchronous reset mid-stream
    @(posedge clk); #1;
    push_n(30, 6000);
    @(negedge clk);
    check("arst_level_pre", level_o, 30);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_a", a_o, 0);
    check("arst_level", level_o, 0);
    check("arst_free", free_o, 64);
    check("arst_popcnt", pop_cnt_o, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    push_n(1, 7000);
    @(negedge clk);
    check("arst_push_level", level_o, 1);
    check("arst_push_a", a_o, 7000);
    @(posedge clk); #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
